// File: rtl/tlul_flush_ctrl_pkg.sv
// rtl/tlul_flush_ctrl_pkg.sv - shared types for the TL-UL gate flush initiator
//
// Purpose: state encoding for tlul_gate_flush_ctrl.
//   The encoding is sparse. Every pair of legal codes differs in at least
//   3 bits, so a single upset cannot turn one legal state into another.
// Contents:
//   tlul_flush_ctrl_state_e  6-bit FSM state (StIdle, StReq, StHeld, StRelease)
//   StResetValue             state loaded on reset
//   flush_req_state()        1 for states that assert flush_req

package tlul_flush_ctrl_pkg;

  // Pairwise Hamming distances:
  //   Idle-Req 3, Idle-Held 3, Idle-Release 4,
  //   Req-Held 6, Req-Release 3, Held-Release 3.
  typedef enum logic [5:0] {
    StIdle    = 6'b000000,
    StReq     = 6'b000111,
    StHeld    = 6'b111000,
    StRelease = 6'b011011
  } tlul_flush_ctrl_state_e;

  localparam tlul_flush_ctrl_state_e StResetValue = StIdle;

  // The request stays asserted from the start of the request phase
  // through the end of the hold phase.
  function automatic logic flush_req_state(tlul_flush_ctrl_state_e s);
    return (s == StReq) || (s == StHeld);
  endfunction

endpackage

// File: rtl/tlul_gate_flush_ctrl_if.sv
// rtl/tlul_gate_flush_ctrl_if.sv - flush_req / flush_ack handshake bundle
//
// Purpose: carries the two-wire handshake between the flush initiator and a
//   lifecycle/flush gate.
// Signals:
//   flush_req_o  initiator -> gate   request to quiesce
//   flush_ack_i  gate -> initiator   gate is quiesced
// Modports:
//   master  initiator side (drives flush_req_o)
//   slave   gate side (drives flush_ack_i)

interface tlul_gate_flush_ctrl_if;

  logic flush_req_o;
  logic flush_ack_i;

  modport master (
    output flush_req_o,
    input  flush_ack_i
  );

  modport slave (
    input  flush_req_o,
    output flush_ack_i
  );

endinterface

// File: rtl/tlul_gate_flush_ctrl.sv
// rtl/tlul_gate_flush_ctrl.sv - initiator FSM for the TL-UL gate flush handshake
//
// Purpose: raises flush_req toward a flush gate and waits for the acknowledge.
//   It then holds the gate quiesced until release. After that it drops the
//   request and waits for the acknowledge to clear. It times out when the gate
//   never acknowledges, and it flags an acknowledge lost during the hold.
// Optional feature: define TLUL_FLUSH_CTRL_LATENCY_EN to record the req->ack
//   latency of the last successful flush on last_latency_o. Without the macro
//   the output is tied to zero and no register is built.
// Ports:
//   clk_i           clock
//   rst_i           async reset, active-high
//   flush_start_i   pulse: begin flush (only seen in StIdle)
//   release_i       pulse: end hold (only seen in StHeld)
//   timeout_i       ack timeout in cycles, 0 disables the timeout
//   gate            handshake to the gate (master modport)
//   busy_o          FSM not idle
//   held_o          gate quiesced
//   done_o          1-cycle pulse: flush finished through release
//   timeout_o       1-cycle pulse: gate did not ack in time
//   abort_o         1-cycle pulse: ack dropped during hold without release
//   err_o           level: illegal state encoding, sticky until reset
//   last_latency_o  req->ack cycles of the last flush

module tlul_gate_flush_ctrl
  import tlul_flush_ctrl_pkg::*;
#(
  parameter int unsigned TimeoutW = 16
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_start_i,
  input  logic                       release_i,
  input  logic [TimeoutW-1:0]        timeout_i,
  tlul_gate_flush_ctrl_if.master     gate,
  output logic                       busy_o,
  output logic                       held_o,
  output logic                       done_o,
  output logic                       timeout_o,
  output logic                       abort_o,
  output logic                       err_o,
  output logic [TimeoutW-1:0]        last_latency_o
);

  localparam logic [TimeoutW-1:0] CntOne = TimeoutW'(1);

  tlul_flush_ctrl_state_e state_q, state_d;
  logic [TimeoutW-1:0]    cnt_q, cnt_d, cnt_inc;
  // Remembers whether StRelease was entered through release_i. Only that
  // path reports done_o on exit.
  logic                   via_rel_q, via_rel_d;
  logic                   done_q, done_d;
  logic                   tmo_q, tmo_d;
  logic                   abort_q, abort_d;
  logic                   illegal;

  // The counter stops at all-ones instead of wrapping back to zero.
  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CntOne;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StResetValue;
      cnt_q     <= '0;
      via_rel_q <= 1'b0;
      done_q    <= 1'b0;
      tmo_q     <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      via_rel_q <= via_rel_d;
      done_q    <= done_d;
      tmo_q     <= tmo_d;
      abort_q   <= abort_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    via_rel_d = via_rel_q;
    done_d    = 1'b0;
    tmo_d     = 1'b0;
    abort_d   = 1'b0;
    illegal   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (flush_start_i) begin
          state_d = StReq;
          cnt_d   = '0;
        end
      end
      StReq: begin
        cnt_d = cnt_inc;
        // When ack and timeout arrive together, the ack wins.
        if (gate.flush_ack_i) begin
          state_d = StHeld;
        end else if ((timeout_i != '0) && (cnt_q == timeout_i - CntOne)) begin
          state_d   = StRelease;
          tmo_d     = 1'b1;
          via_rel_d = 1'b0;
        end
      end
      StHeld: begin
        // A release that arrives with the ack drop counts as a normal release.
        if (release_i) begin
          state_d   = StRelease;
          via_rel_d = 1'b1;
        end else if (!gate.flush_ack_i) begin
          state_d   = StRelease;
          abort_d   = 1'b1;
          via_rel_d = 1'b0;
        end
      end
      StRelease: begin
        if (!gate.flush_ack_i) begin
          state_d   = StIdle;
          done_d    = via_rel_q;
          via_rel_d = 1'b0;
        end
      end
      default: begin
        // Stay in the corrupted code so that err_o stays set until reset.
        illegal = 1'b1;
      end
    endcase
  end

  assign gate.flush_req_o = flush_req_state(state_q);
  assign busy_o           = (state_q != StIdle);
  assign held_o           = (state_q == StHeld);
  assign done_o           = done_q;
  assign timeout_o        = tmo_q;
  assign abort_o          = abort_q;
  assign err_o            = illegal;

`ifdef TLUL_FLUSH_CTRL_LATENCY_EN
  logic                lat_load;
  logic [TimeoutW-1:0] lat_q;

  // Latency counts the request cycles including the cycle in which ack was
  // seen. It is updated only on the StReq->StHeld transition.
  assign lat_load = (state_q == StReq) && gate.flush_ack_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lat_q <= '0;
    end else if (lat_load) begin
      lat_q <= cnt_inc;
    end
  end

  assign last_latency_o = lat_q;
`else
  assign last_latency_o = '0;
`endif

endmodule

// File: tb/tb_tlul_gate_flush_ctrl.sv
// tb/tb_tlul_gate_flush_ctrl.sv - directed bench for tlul_gate_flush_ctrl
//
// Purpose: drives flush sequences, gate acknowledges and resets, and checks
//   the handshake, status pulses and latency against hand-computed values.
// Ports: none (top-level bench).

module tb_tlul_gate_flush_ctrl;

`ifdef TLUL_FLUSH_CTRL_LATENCY_EN
  localparam bit LatOn = 1'b1;
`else
  localparam bit LatOn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush_start;
  logic        rel;
  logic [15:0] tmo;
  logic        busy, held, done, timeout, abort, err;
  logic [15:0] last_latency;

  int pass_cnt  = 0;
  int total_cnt = 0;

  tlul_gate_flush_ctrl_if gif ();

  tlul_gate_flush_ctrl #(.TimeoutW(16)) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .flush_start_i  (flush_start),
    .release_i      (rel),
    .timeout_i      (tmo),
    .gate           (gif),
    .busy_o         (busy),
    .held_o         (held),
    .done_o         (done),
    .timeout_o      (timeout),
    .abort_o        (abort),
    .err_o          (err),
    .last_latency_o (last_latency)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush_start = 1'b0; rel = 1'b0; tmo = '0; gif.flush_ack_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (gif.flush_req_o !== 1'b0) $display("FAIL reset_req: got %b expected 0", gif.flush_req_o); else pass_cnt++;
    total_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (held !== 1'b0) $display("FAIL reset_held: got %b expected 0", held); else pass_cnt++;
    total_cnt++; if ({done, timeout, abort, err} !== 4'b0000) $display("FAIL reset_pulses: got %b expected 0000", {done, timeout, abort, err}); else pass_cnt++;
    total_cnt++; if (last_latency !== 16'd0) $display("FAIL reset_latency: got %0d expected 0", last_latency); else pass_cnt++;
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic_flush();
    logic [15:0] exp_lat;
    exp_lat = LatOn ? 16'd3 : 16'd0;
    tmo = 16'd0;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    total_cnt++; if ({gif.flush_req_o, busy, held} !== 3'b110) $display("FAIL basic_req: got %b expected 110", {gif.flush_req_o, busy, held}); else pass_cnt++;
    step(); step();
    gif.flush_ack_i = 1'b1;
    step();
    total_cnt++; if ({gif.flush_req_o, held} !== 2'b11) $display("FAIL basic_held: got %b expected 11", {gif.flush_req_o, held}); else pass_cnt++;
    total_cnt++; if (last_latency !== exp_lat) $display("FAIL basic_latency: got %0d expected %0d", last_latency, exp_lat); else pass_cnt++;
    repeat (4) step();
    rel = 1'b1; step(); rel = 1'b0;
    total_cnt++; if ({gif.flush_req_o, held, busy, done} !== 4'b0010) $display("FAIL basic_release: got %b expected 0010", {gif.flush_req_o, held, busy, done}); else pass_cnt++;
    gif.flush_ack_i = 1'b0;
    step();
    total_cnt++; if ({done, busy} !== 2'b10) $display("FAIL basic_done: got %b expected 10", {done, busy}); else pass_cnt++;
    step();
    total_cnt++; if (done !== 1'b0) $display("FAIL basic_done_once: got %b expected 0", done); else pass_cnt++;
  endtask

  task automatic test_timeout();
    int req_n, tmo_n, done_n;
    logic [15:0] exp_lat;
    exp_lat = LatOn ? 16'd3 : 16'd0;
    req_n = 0; tmo_n = 0; done_n = 0;
    tmo = 16'd4;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gif.flush_req_o) req_n++;
      if (timeout) tmo_n++;
      if (done) done_n++;
      step();
    end
    total_cnt++; if (req_n !== 4) $display("FAIL timeout_req_cycles: got %0d expected 4", req_n); else pass_cnt++;
    total_cnt++; if (tmo_n !== 1) $display("FAIL timeout_pulses: got %0d expected 1", tmo_n); else pass_cnt++;
    total_cnt++; if ({done_n != 0, busy} !== 2'b00) $display("FAIL timeout_idle_nodone: got %b expected 00", {done_n != 0, busy}); else pass_cnt++;
    total_cnt++; if (last_latency !== exp_lat) $display("FAIL timeout_latency_kept: got %0d expected %0d", last_latency, exp_lat); else pass_cnt++;
  endtask

  task automatic test_ack_at_timeout();
    logic [15:0] exp_lat;
    exp_lat = LatOn ? 16'd4 : 16'd0;
    tmo = 16'd4;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    step(); step(); step();
    gif.flush_ack_i = 1'b1;
    step();
    total_cnt++; if ({held, timeout} !== 2'b10) $display("FAIL ackwin_held: got %b expected 10", {held, timeout}); else pass_cnt++;
    total_cnt++; if (last_latency !== exp_lat) $display("FAIL ackwin_latency: got %0d expected %0d", last_latency, exp_lat); else pass_cnt++;
    step();
    total_cnt++; if ({held, timeout} !== 2'b10) $display("FAIL ackwin_no_timeout: got %b expected 10", {held, timeout}); else pass_cnt++;
    rel = 1'b1; step(); rel = 1'b0;
    gif.flush_ack_i = 1'b0;
    step(); step();
    total_cnt++; if (busy !== 1'b0) $display("FAIL ackwin_idle: got %b expected 0", busy); else pass_cnt++;
  endtask

  task automatic test_no_timeout_and_abort();
    int tmo_n;
    logic [15:0] exp_lat;
    exp_lat = LatOn ? 16'd1001 : 16'd0;
    tmo_n = 0;
    tmo = 16'd0;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (timeout) tmo_n++;
      step();
    end
    total_cnt++; if ({tmo_n != 0, gif.flush_req_o} !== 2'b01) $display("FAIL notmo_still_req: got %b expected 01", {tmo_n != 0, gif.flush_req_o}); else pass_cnt++;
    gif.flush_ack_i = 1'b1;
    step();
    total_cnt++; if (held !== 1'b1) $display("FAIL notmo_held: got %b expected 1", held); else pass_cnt++;
    total_cnt++; if (last_latency !== exp_lat) $display("FAIL notmo_latency: got %0d expected %0d", last_latency, exp_lat); else pass_cnt++;
    step();
    gif.flush_ack_i = 1'b0;
    step();
    total_cnt++; if ({abort, gif.flush_req_o, held} !== 3'b100) $display("FAIL abort_pulse: got %b expected 100", {abort, gif.flush_req_o, held}); else pass_cnt++;
    step();
    total_cnt++; if ({abort, done, busy} !== 3'b000) $display("FAIL abort_idle: got %b expected 000", {abort, done, busy}); else pass_cnt++;
  endtask

  task automatic test_release_with_drop();
    tmo = 16'd0;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    gif.flush_ack_i = 1'b1;
    step();
    rel = 1'b1; gif.flush_ack_i = 1'b0;
    step();
    rel = 1'b0;
    total_cnt++; if ({abort, gif.flush_req_o, busy} !== 3'b001) $display("FAIL reldrop_no_abort: got %b expected 001", {abort, gif.flush_req_o, busy}); else pass_cnt++;
    step();
    total_cnt++; if ({done, busy} !== 2'b10) $display("FAIL reldrop_done: got %b expected 10", {done, busy}); else pass_cnt++;
    step();
  endtask

  task automatic test_ignored_inputs();
    int req_n, tmo_n;
    req_n = 0; tmo_n = 0;
    rel = 1'b1; step(); rel = 1'b0;
    total_cnt++; if (busy !== 1'b0) $display("FAIL ignore_rel_idle: got %b expected 0", busy); else pass_cnt++;
    tmo = 16'd4;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (gif.flush_req_o) req_n++;
      if (timeout) tmo_n++;
      flush_start = (i == 1);
      rel = (i == 2);
      step();
    end
    flush_start = 1'b0; rel = 1'b0;
    total_cnt++; if (req_n !== 4) $display("FAIL ignore_start_busy: got %0d req cycles expected 4", req_n); else pass_cnt++;
    total_cnt++; if ({tmo_n == 1, busy} !== 2'b10) $display("FAIL ignore_timeout_idle: got %b expected 10", {tmo_n == 1, busy}); else pass_cnt++;
  endtask

  task automatic test_reset_mid_hold();
    tmo = 16'd0;
    flush_start = 1'b1; step(); flush_start = 1'b0;
    gif.flush_ack_i = 1'b1;
    step();
    total_cnt++; if (held !== 1'b1) $display("FAIL rstmid_held: got %b expected 1", held); else pass_cnt++;
    #1 rst = 1'b1;
    #1;
    total_cnt++; if ({gif.flush_req_o, held, busy} !== 3'b000) $display("FAIL rstmid_async: got %b expected 000", {gif.flush_req_o, held, busy}); else pass_cnt++;
    gif.flush_ack_i = 1'b0;
    step();
    rst = 1'b0;
    step();
    total_cnt++; if (last_latency !== 16'd0) $display("FAIL rstmid_latency: got %0d expected 0", last_latency); else pass_cnt++;
    total_cnt++; if (err !== 1'b0) $display("FAIL rstmid_err: got %b expected 0", err); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_flush();
    test_timeout();
    test_ack_at_timeout();
    test_no_timeout_and_abort();
    test_release_with_drop();
    test_ignored_inputs();
    test_reset_mid_hold();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
